// File: rtl/word_selector_if.sv
// Word selector bus: grab request, random index, word-ROM port and word handshake.
// master = word_selector side, slave = game logic / RNG / ROM side.
interface word_selector_if #(
  parameter int unsigned WORD_W = 40,
  parameter int unsigned IDX_W  = 7
);
  logic              grab_word;
  logic [IDX_W-1:0]  random_num;
  logic [IDX_W-1:0]  rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;
  logic [IDX_W-1:0]  word_index;
  logic              busy;

  modport master (
    input  grab_word, random_num, rom_data, word_ready,
    output rom_addr, word, word_valid, word_index, busy
  );

  modport slave (
    output grab_word, random_num, rom_data, word_ready,
    input  rom_addr, word, word_valid, word_index, busy
  );
endinterface

// File: rtl/word_selector.sv
// Picks a word from an external synchronous ROM on a grab edge, folding the random
// index into range and rejecting an immediate repeat; delivers it over valid/ready.
module word_selector #(
  parameter int unsigned WORD_COUNT = 100,
  parameter int unsigned LETTER_W   = 8,
  parameter int unsigned WORD_LEN   = 5
) (
  input  logic clk,
  input  logic reset,
  word_selector_if.master bus
);
  localparam int unsigned WORD_W = LETTER_W * WORD_LEN;
  localparam int unsigned IDX_W  = 7;
  localparam logic [IDX_W-1:0] COUNT_IDX = IDX_W'(WORD_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_COUNT - 1);
  localparam logic [IDX_W:0]   COUNT_EXT = (IDX_W + 1)'(WORD_COUNT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAP   = 3'd1,
    FETCH = 3'd2,
    CAPT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx_r, idx_n;
  logic [IDX_W-1:0]    addr_r, addr_n;
  logic [WORD_W-1:0]   word_r, word_n;
  logic                valid_r, valid_n;
  logic [IDX_W-1:0]    index_r, index_n;
  logic                busy_r, busy_n;
  logic                have_last, have_last_n;
  logic                grab_q;
  logic                grab_edge_c;
  logic [IDX_W-1:0]    fold_c;
  logic [IDX_W-1:0]    pick_c;

  assign grab_edge_c = bus.grab_word & ~grab_q;

  // One conditional subtraction suffices because WORD_COUNT >= 64.
  always_comb begin
    fold_c = idx_r;
    if ({1'b0, idx_r} >= COUNT_EXT) fold_c = idx_r - COUNT_IDX;
    pick_c = fold_c;
    if (have_last && (fold_c == index_r))
      pick_c = (fold_c == LAST_IDX) ? '0 : fold_c + IDX_W'(1);
  end

  // Next-state and next-register values.
  always_comb begin
    state_n     = state;
    idx_n       = idx_r;
    addr_n      = addr_r;
    word_n      = word_r;
    valid_n     = valid_r;
    index_n     = index_r;
    have_last_n = have_last;
    case (state)
      IDLE: begin
        if (grab_edge_c) begin
          idx_n   = bus.random_num;
          state_n = MAP;
        end
      end
      MAP: begin
        addr_n  = pick_c;
        state_n = FETCH;
      end
      FETCH: state_n = CAPT;
      CAPT: begin
        word_n      = bus.rom_data;
        index_n     = addr_r;
        have_last_n = 1'b1;
        valid_n     = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (bus.word_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // grab_q resets high so a grab level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx_r     <= '0;
      addr_r    <= '0;
      word_r    <= '0;
      valid_r   <= 1'b0;
      index_r   <= '0;
      busy_r    <= 1'b0;
      have_last <= 1'b0;
      grab_q    <= 1'b1;
    end else begin
      state     <= state_n;
      idx_r     <= idx_n;
      addr_r    <= addr_n;
      word_r    <= word_n;
      valid_r   <= valid_n;
      index_r   <= index_n;
      busy_r    <= busy_n;
      have_last <= have_last_n;
      grab_q    <= bus.grab_word;
    end
  end

  assign bus.rom_addr   = addr_r;
  assign bus.word       = word_r;
  assign bus.word_valid = valid_r;
  assign bus.word_index = index_r;
  assign bus.busy       = busy_r;

endmodule

// File: doc/word_selector.md
Name: word_selector

Overview:
- Downstream consumer of the 7-bit random number generator. On a grab request it samples `random_num` and folds it into the valid word-list range.
- It rejects an immediate repeat of the previously chosen word, reads the word from an external synchronous word ROM, and presents the packed ASCII word to game logic over a valid/ready handshake.

Parameters:
- WORD_COUNT, 100, number of ROM entries; legal range 64..128, so one conditional subtraction always folds a 7-bit index.
- LETTER_W, 8, bits per letter (ASCII).
- WORD_LEN, 5, letters per word. WORD_W = LETTER_W*WORD_LEN = 40.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- grab_word  in  1  request for a new word; rising-edge detected internally.
- random_num  in  7  random index from the RNG; sampled only on an accepted grab.
- rom_addr  out  7  registered word-ROM address.
- rom_data  in  WORD_W  ROM read data; valid one cycle after the ROM clocks `rom_addr`.
- word  out  WORD_W  selected word, letter 0 in the MSBs; held stable while `word_valid` is high.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts the word.
- word_index  out  7  ROM index of the last delivered word.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; word=0, word_valid=0, rom_addr=0, word_index=0, busy=0; have_last=0.
  - grab_q is reset to 1, so a grab_word level held through reset release does not trigger a fetch.
  - Reset overrides every state, including mid-fetch; the in-flight fetch is discarded.
- Grab edge: grab_edge = grab_word & ~grab_q. grab_q updates every cycle in every state.
- States: IDLE, MAP, FETCH, CAPT, HOLD.
  - IDLE: if grab_edge, idx_r <= random_num and go to MAP; otherwise stay.
  - MAP: fold the index, apply the repeat check, register the result into rom_addr, go to FETCH.
    - Fold: f = (idx_r >= WORD_COUNT) ? idx_r - WORD_COUNT : idx_r.
    - Repeat check: if have_last && f == word_index, f = (f == WORD_COUNT-1) ? 0 : f+1.
  - FETCH: rom_addr held stable while the ROM latches it; go to CAPT.
  - CAPT: word <= rom_data, word_index <= rom_addr, have_last <= 1, word_valid <= 1; go to HOLD.
  - HOLD: word_valid stays 1. If word_ready==1 at an edge, word_valid <= 0 and go to IDLE. `word` retains its value after acceptance.
- Latency: grab_edge sampled at edge E0. rom_addr is valid after E1. word_valid rises after E3 (3 cycles). The earliest next grab is accepted in the cycle after return to IDLE.
- Ignored inputs:
  - grab edges in any state other than IDLE are ignored, not queued.
  - word_ready while word_valid==0 is ignored.
- Width rules: all index arithmetic is 7-bit unsigned. idx_r - WORD_COUNT cannot underflow because it is guarded by the compare.
- random_num changing after E0 has no effect on the fetch in progress.

Test Plan:
- Reset held low for 3 cycles, grab_word=1 throughout and after release -> word_valid=0, word=0, rom_addr=0, busy=0; no fetch starts after release until grab_word goes 0 then 1.
- ROM[17]=0x4150504C45 ("APPLE"), random_num=17, one-cycle grab pulse -> rom_addr=17 after E1; word_valid=1 after E3 with word=0x4150504C45 and word_index=17; valid held for 5 cycles with word_ready=0; word_ready=1 -> valid=0 next cycle, busy=0.
- Fold: random_num=115, WORD_COUNT=100 -> rom_addr=15; random_num=99 -> rom_addr=99; random_num=100 -> rom_addr=0.
- Repeat rejection: last word_index=15, random_num=15 -> rom_addr=16. Last word_index=99, random_num=99 -> rom_addr=0 (wrap). Last word_index=99, random_num=127 -> rom_addr=27.
- Handshake abuse:
  - grab_word held high for 10 cycles -> exactly one fetch.
  - Extra grab pulse during HOLD -> ignored; valid stays high, word unchanged.
  - word_ready=1 while in IDLE -> no state change.
- Reset mid-operation: reset=0 for one cycle while in FETCH -> next cycle state IDLE, word_valid=0, busy=0, have_last=0. A following grab with random_num=17 after a prior delivery of index 17 yields rom_addr=17 (no repeat bump).
